// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite mover: key FSM states,
// movement directions and the bit positions of player_input.
package sprite_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE,
        KEY_HELD,
        KEY_REPEAT
    } key_state_t;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    localparam int IN_UP    = 3;
    localparam int IN_DOWN  = 2;
    localparam int IN_LEFT  = 1;
    localparam int IN_RIGHT = 0;

    // Highest set bit wins, so simultaneous keys never produce a diagonal.
    function automatic dir_t select_dir(input logic [3:0] keys);
        if (keys[IN_UP])         return DIR_UP;
        else if (keys[IN_DOWN])  return DIR_DOWN;
        else if (keys[IN_LEFT])  return DIR_LEFT;
        else if (keys[IN_RIGHT]) return DIR_RIGHT;
        else                     return DIR_NONE;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Key press/auto-repeat FSM: turns the held player keys into a direction
// and a combinational move strobe (first press, then delay, then rate).
module key_repeat
    import sprite_pkg::*;
#(
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_freeze,
    input  logic [3:0] i_keys,
    output logic [2:0] o_dir,
    output logic       o_move
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    key_state_t       r_state, w_state_nxt;
    dir_t             r_dir, w_dir_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_block, w_block_nxt;
    dir_t             w_sel;

    assign w_sel = select_dir(i_keys);
    assign o_dir = w_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= KEY_IDLE;
            r_dir   <= DIR_NONE;
            r_cnt   <= '0;
            // A key held through reset must be released before it counts.
            r_block <= (i_keys != 4'd0);
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_cnt   <= w_cnt_nxt;
            r_block <= w_block_nxt;
        end
    end

    // r_cnt holds the number of cycles since the last move event.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_block_nxt = r_block;
        o_move      = 1'b0;
        if (i_freeze) begin
            w_state_nxt = KEY_IDLE;
            w_dir_nxt   = DIR_NONE;
            w_cnt_nxt   = '0;
            w_block_nxt = (w_sel != DIR_NONE);
        end else if (w_sel == DIR_NONE) begin
            w_state_nxt = KEY_IDLE;
            w_dir_nxt   = DIR_NONE;
            w_cnt_nxt   = '0;
            w_block_nxt = 1'b0;
        end else if (!r_block) begin
            if (r_state == KEY_IDLE || w_sel != r_dir) begin
                o_move      = 1'b1;
                w_state_nxt = KEY_HELD;
                w_dir_nxt   = w_sel;
                w_cnt_nxt   = CNT_W'(1);
            end else if (r_state == KEY_HELD && r_cnt == CNT_W'(REPEAT_DELAY)) begin
                o_move      = 1'b1;
                w_state_nxt = KEY_REPEAT;
                w_cnt_nxt   = CNT_W'(1);
            end else if (r_state == KEY_REPEAT && r_cnt == CNT_W'(REPEAT_RATE)) begin
                o_move      = 1'b1;
                w_cnt_nxt   = CNT_W'(1);
            end else begin
                w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_mover.sv
// Grid sprite: holds position and lives, applies steps from key_repeat,
// handles edge clamp/wrap, goal respawn, hits and the dead/frozen states.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int GRID_W       = 16,
    parameter int GRID_H       = 16,
    parameter int START_X      = 0,
    parameter int START_Y      = 8,
    parameter int WRAP_X       = 0,
    parameter int LIVES        = 3,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      new_game,
    input  logic                      freeze,
    input  logic [3:0]                player_input,
    input  logic                      hit,
    output logic [$clog2(GRID_W)-1:0] pos_x,
    output logic [$clog2(GRID_H)-1:0] pos_y,
    output logic [3:0]                lives,
    output logic                      moved,
    output logic                      goal,
    output logic                      dead
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
    localparam logic [XW-1:0] X_START = XW'(START_X);
    localparam logic [YW-1:0] Y_START = YW'(START_Y);

    logic [XW-1:0] r_x, w_x_step;
    logic [YW-1:0] r_y, w_y_step;
    logic [3:0]    r_lives;
    logic          r_moved, r_goal;
    logic          w_restart, w_dead, w_move, w_step_ok;
    logic [2:0]    w_dir;

    assign w_restart = reset | new_game;
    assign w_dead    = (r_lives == 4'd0);

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_key_repeat (
        .clk      (clk),
        .reset    (w_restart),
        .i_freeze (freeze),
        .i_keys   (player_input),
        .o_dir    (w_dir),
        .o_move   (w_move)
    );

    always_comb begin
        w_x_step  = r_x;
        w_y_step  = r_y;
        w_step_ok = 1'b0;
        case (w_dir)
            DIR_UP:    if (r_y != Y_MAX) begin w_y_step = r_y + YW'(1); w_step_ok = 1'b1; end
            DIR_DOWN:  if (r_y != '0)    begin w_y_step = r_y - YW'(1); w_step_ok = 1'b1; end
            DIR_LEFT: begin
                if (r_x != '0) begin
                    w_x_step  = r_x - XW'(1);
                    w_step_ok = 1'b1;
                end else if (WRAP_X != 0) begin
                    w_x_step  = X_MAX;
                    w_step_ok = 1'b1;
                end
            end
            DIR_RIGHT: begin
                if (r_x != X_MAX) begin
                    w_x_step  = r_x + XW'(1);
                    w_step_ok = 1'b1;
                end else if (WRAP_X != 0) begin
                    w_x_step  = '0;
                    w_step_ok = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Priority: restart > freeze/dead hold > hit > goal-row respawn > step.
    always_ff @(posedge clk) begin
        if (w_restart) begin
            r_x     <= X_START;
            r_y     <= Y_START;
            r_lives <= 4'(LIVES);
            r_moved <= 1'b0;
            r_goal  <= 1'b0;
        end else begin
            r_moved <= 1'b0;
            r_goal  <= 1'b0;
            if (freeze || w_dead) begin
                r_x <= r_x;
            end else if (hit) begin
                r_lives <= r_lives - 4'd1;
                r_x     <= X_START;
                r_y     <= Y_START;
            end else if (r_y == Y_MAX) begin
                r_x <= X_START;
                r_y <= Y_START;
            end else if (w_move && w_step_ok) begin
                r_x     <= w_x_step;
                r_y     <= w_y_step;
                r_moved <= 1'b1;
                r_goal  <= (w_y_step == Y_MAX);
            end
        end
    end

    assign pos_x = r_x;
    assign pos_y = r_y;
    assign lives = r_lives;
    assign moved = r_moved;
    assign goal  = r_goal;
    assign dead  = w_dead;

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: two instances (clamp and wrap) driven together,
// directed scenarios plus random key/hit/freeze traffic against a model.
module tb_sprite_mover;

    logic       clk = 1'b0;
    logic       reset = 1'b1, new_game = 1'b0, freeze = 1'b0, hit = 1'b0;
    logic [3:0] keys = 4'd0;

    logic [3:0] x0, y0, l0, x1, y1, l1;
    logic       mv0, g0, d0, mv1, g1, d1;

    always #5 clk = ~clk;

    sprite_mover dut0 (
        .clk(clk), .reset(reset), .new_game(new_game), .freeze(freeze),
        .player_input(keys), .hit(hit),
        .pos_x(x0), .pos_y(y0), .lives(l0), .moved(mv0), .goal(g0), .dead(d0)
    );

    sprite_mover #(
        .WRAP_X(1), .START_Y(5), .LIVES(2), .REPEAT_DELAY(3), .REPEAT_RATE(2)
    ) dut1 (
        .clk(clk), .reset(reset), .new_game(new_game), .freeze(freeze),
        .player_input(keys), .hit(hit),
        .pos_x(x1), .pos_y(y1), .lives(l1), .moved(mv1), .goal(g1), .dead(d1)
    );

    localparam int GW = 16, GH = 16, SX = 0;
    int p_sy[2]   = '{8, 5};
    int p_lv[2]   = '{3, 2};
    int p_dly[2]  = '{8, 3};
    int p_rate[2] = '{4, 2};
    int p_wrap[2] = '{0, 1};

    typedef struct {
        int x, y, lives;
        bit moved, goal;
        bit blocked, active;
        int adir, t;
    } mdl_t;
    mdl_t m[2];

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // 1=up 2=down 3=left 4=right, highest key bit first
    function automatic int prio(input logic [3:0] k);
        if (k[3]) return 1;
        if (k[2]) return 2;
        if (k[1]) return 3;
        if (k[0]) return 4;
        return 0;
    endfunction

    task automatic model_step(input int i);
        bit mv;
        int d, nx, ny;
        mv = 0;
        d  = prio(keys);
        if (reset || new_game) begin
            m[i].blocked = (keys != 0);
            m[i].active  = 0;
        end else if (freeze) begin
            m[i].blocked = (keys != 0);
            m[i].active  = 0;
        end else if (d == 0) begin
            m[i].blocked = 0;
            m[i].active  = 0;
        end else if (!m[i].blocked) begin
            if (!m[i].active || d != m[i].adir) begin
                mv = 1; m[i].active = 1; m[i].adir = d; m[i].t = 0;
            end else begin
                m[i].t++;
                if (m[i].t == p_dly[i]) mv = 1;
                else if (m[i].t > p_dly[i] && (m[i].t - p_dly[i]) % p_rate[i] == 0) mv = 1;
            end
        end
        if (reset || new_game) begin
            m[i].x = SX; m[i].y = p_sy[i]; m[i].lives = p_lv[i];
            m[i].moved = 0; m[i].goal = 0;
        end else begin
            m[i].moved = 0; m[i].goal = 0;
            if (freeze || m[i].lives == 0) begin
                // holds
            end else if (hit) begin
                m[i].lives--; m[i].x = SX; m[i].y = p_sy[i];
            end else if (m[i].y == GH - 1) begin
                m[i].x = SX; m[i].y = p_sy[i];
            end else if (mv) begin
                nx = m[i].x; ny = m[i].y;
                case (d)
                    1: ny = ny + 1;
                    2: ny = ny - 1;
                    3: nx = (nx == 0 && p_wrap[i] != 0) ? GW - 1 : nx - 1;
                    4: nx = (nx == GW - 1 && p_wrap[i] != 0) ? 0 : nx + 1;
                    default: ;
                endcase
                if (nx >= 0 && nx < GW && ny >= 0 && ny < GH) begin
                    m[i].x = nx; m[i].y = ny; m[i].moved = 1;
                    m[i].goal = (ny == GH - 1);
                end
            end
        end
    endtask

    task automatic compare_all();
        check("d0.pos_x", x0, m[0].x);   check("d0.pos_y", y0, m[0].y);
        check("d0.lives", l0, m[0].lives); check("d0.moved", mv0, m[0].moved);
        check("d0.goal", g0, m[0].goal); check("d0.dead", d0, m[0].lives == 0);
        check("d1.pos_x", x1, m[1].x);   check("d1.pos_y", y1, m[1].y);
        check("d1.lives", l1, m[1].lives); check("d1.moved", mv1, m[1].moved);
        check("d1.goal", g1, m[1].goal); check("d1.dead", d1, m[1].lives == 0);
    endtask

    task automatic tick(input logic [3:0] k, input bit h, input bit fz, input bit ng, input bit rs);
        keys = k; hit = h; freeze = fz; new_game = ng; reset = rs;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic key(input logic [3:0] k);
        tick(k, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        tick(4'd0, 0, 0, 0, 1);
        tick(4'd0, 0, 0, 0, 1);
        key(4'd0);
    endtask

    initial begin
        logic [3:0] rk;
        int len;

        do_reset();
        check("reset_x", x0, 0); check("reset_y", y0, 8);
        check("reset_lives", l0, 3); check("reset_dead", d0, 0);

        key(4'b0001);
        check("pulse_x", x0, 1); check("pulse_moved", mv0, 1); check("pulse_lives", l0, 3);
        key(4'd0);
        check("pulse_moved_drop", mv0, 0);

        do_reset();
        for (int c = 0; c < 21; c++) key(4'b0001);
        check("repeat_x", x0, 5);

        do_reset();
        for (int c = 0; c < 15; c++) begin key(4'b0001); key(4'd0); end
        check("edge_x", x0, 15);
        key(4'b0001);
        check("clamp_x", x0, 15); check("clamp_moved", mv0, 0);
        check("wrap_x", x1, 0);   check("wrap_moved", mv1, 1);
        key(4'd0);

        do_reset();
        for (int c = 0; c < 6; c++) begin key(4'b1000); key(4'd0); end
        check("pre_goal_y", y0, 14);
        key(4'b1000);
        check("goal_pulse", g0, 1); check("goal_moved", mv0, 1);
        key(4'd0);
        check("goal_respawn_x", x0, 0); check("goal_respawn_y", y0, 8); check("goal_drop", g0, 0);

        do_reset();
        tick(4'b0001, 1, 0, 0, 0);
        check("hit_lives", l0, 2); check("hit_x", x0, 0); check("hit_moved", mv0, 0);
        key(4'd0); tick(4'd0, 1, 0, 0, 0); key(4'd0); tick(4'd0, 1, 0, 0, 0);
        check("dead_flag", d0, 1);
        key(4'b1000); key(4'd0); tick(4'd0, 1, 0, 0, 0);
        check("dead_hold_y", y0, 8); check("dead_lives", l0, 0);
        tick(4'd0, 0, 0, 1, 0);
        check("newgame_lives", l0, 3); check("newgame_dead", d0, 0);

        do_reset();
        for (int c = 0; c < 10; c++) tick(4'b1000, 0, 1, 0, 0);
        check("freeze_y", y0, 8);
        for (int c = 0; c < 3; c++) key(4'b1000);
        check("unfreeze_held_y", y0, 8);
        key(4'd0); key(4'b1000);
        check("repress_y", y0, 9);

        do_reset();
        for (int c = 0; c < 10; c++) key(4'b0001);
        tick(4'b0001, 0, 0, 0, 1);
        for (int c = 0; c < 5; c++) key(4'b0001);
        check("reset_abort_x", x0, 0);
        key(4'd0); key(4'b0001);
        check("after_reset_press_x", x0, 1);

        for (int s = 0; s < 300; s++) begin
            rk  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (4'd1 << $urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) rk = 4'd0;
            len = $urandom_range(1, 25);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 15) == 0) rk = 4'd1 << $urandom_range(0, 3);
                tick(rk, $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                     $urandom_range(0, 149) == 0, $urandom_range(0, 299) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
